// File: rtl/iomem_pkg.sv
// Shared types and widths for the iomem bus arbiter.
package iomem_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int IOMEM_AW = 32;
  localparam int IOMEM_DW = 32;
  localparam int IOMEM_SW = 4;

  // Read data handed back when the decode never answers.
  localparam logic [IOMEM_DW-1:0] IOMEM_TIMEOUT_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/iomem_arbiter_if.sv
// One valid/ready iomem channel. A requester uses the master view and a
// responder uses the slave view.
interface iomem_arbiter_if;
  import iomem_pkg::*;

  logic                valid;
  logic                ready;
  logic [IOMEM_AW-1:0] addr;
  logic [IOMEM_DW-1:0] wdata;
  logic [IOMEM_SW-1:0] wstrb;
  logic [IOMEM_DW-1:0] rdata;

  modport master (
    output valid, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  valid, addr, wdata, wstrb,
    output ready, rdata
  );

endinterface

// File: rtl/iomem_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// requester that was not granted last.
module iomem_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_id,
  output logic       any
);

  // Winner selection.
  always_comb begin
    any    = |req;
    gnt_id = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/iomem_arbiter.sv
// Two-master round-robin arbiter for the shared iomem bus, with a watchdog
// that completes transactions the address decode never acknowledges.
module iomem_arbiter
  import iomem_pkg::*;
#(
  parameter int unsigned         TIMEOUT_CYCLES = 255,
  parameter logic [IOMEM_DW-1:0] TIMEOUT_RDATA  = IOMEM_TIMEOUT_RDATA
) (
  input  logic             clk,
  input  logic             rst,
  iomem_arbiter_if.slave   m0,
  iomem_arbiter_if.slave   m1,
  iomem_arbiter_if.master  s,
  output logic             grant,
  output logic             timeout_err
);

  localparam logic [15:0] CNT_TC  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_t              state_q, state_d;
  logic                grant_q;
  logic                last_q;
  logic [15:0]         cnt_q;
  logic                err_q;

  logic                pick_id;
  logic                pick_any;
  logic                busy;
  logic                g_valid;
  logic [IOMEM_AW-1:0] g_addr;
  logic [IOMEM_DW-1:0] g_wdata;
  logic [IOMEM_SW-1:0] g_wstrb;
  logic                s_valid_c;
  logic                done;
  logic                timed_out;
  logic [IOMEM_DW-1:0] resp_rdata;

  iomem_rr_pick u_pick (
    .req    ({m1.valid, m0.valid}),
    .last   (last_q),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  // Request mux from the current grantee.
  always_comb begin
    g_valid = grant_q ? m1.valid : m0.valid;
    g_addr  = grant_q ? m1.addr  : m0.addr;
    g_wdata = grant_q ? m1.wdata : m0.wdata;
    g_wstrb = grant_q ? m1.wstrb : m0.wstrb;
  end

  // Next state and completion decode. s_ready outranks the watchdog; a
  // grantee withdrawing its request aborts without a ready pulse.
  always_comb begin
    state_d    = state_q;
    s_valid_c  = 1'b0;
    done       = 1'b0;
    timed_out  = 1'b0;
    resp_rdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (!g_valid) begin
          state_d = ST_IDLE;
        end else if (s.ready) begin
          s_valid_c  = 1'b1;
          done       = 1'b1;
          resp_rdata = s.rdata;
          state_d    = ST_IDLE;
        end else if (cnt_q == CNT_TC) begin
          done       = 1'b1;
          timed_out  = 1'b1;
          resp_rdata = TIMEOUT_RDATA;
          state_d    = ST_IDLE;
        end else begin
          s_valid_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy     = (state_q == ST_BUSY);
  assign s.valid  = s_valid_c;
  assign s.addr   = busy ? g_addr  : '0;
  assign s.wdata  = busy ? g_wdata : '0;
  assign s.wstrb  = busy ? g_wstrb : '0;
  assign m0.ready = done & ~grant_q;
  assign m1.ready = done & grant_q;
  assign m0.rdata = (done & ~grant_q) ? resp_rdata : '0;
  assign m1.rdata = (done & grant_q)  ? resp_rdata : '0;
  assign grant       = grant_q;
  assign timeout_err = err_q;

  // State, grant, round-robin pointer, saturating wait counter, sticky error.
  // A watchdog completion still counts as a served turn for fairness.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (!busy && pick_any) grant_q <= pick_id;
      if (done) last_q <= grant_q;
      if (busy && state_d == ST_BUSY) begin
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 16'd1;
      end else begin
        cnt_q <= '0;
      end
      if (timed_out) err_q <= 1'b1;
    end
  end

endmodule
